// File: rtl/dmi_sba_responder_if.sv
// rtl/dmi_sba_responder_if.sv - DMI request/response and SBA bus master signal bundle
interface dmi_sba_responder_if #(
    parameter int unsigned BusAw = 32
) ();
    logic             dmi_req_valid_i;
    logic             dmi_req_ready_o;
    logic [6:0]       dmi_req_addr_i;
    logic [1:0]       dmi_req_op_i;
    logic [31:0]      dmi_req_data_i;
    logic             dmi_resp_valid_o;
    logic             dmi_resp_ready_i;
    logic [31:0]      dmi_resp_data_o;
    logic [1:0]       dmi_resp_resp_o;
    logic             bus_req_o;
    logic             bus_gnt_i;
    logic             bus_we_o;
    logic [BusAw-1:0] bus_addr_o;
    logic [31:0]      bus_wdata_o;
    logic [3:0]       bus_be_o;
    logic             bus_rvalid_i;
    logic [31:0]      bus_rdata_i;
    logic             bus_err_i;

    // The responder: DMI target on one side, bus initiator on the other
    modport slave (
        input  dmi_req_valid_i, dmi_req_addr_i, dmi_req_op_i, dmi_req_data_i, dmi_resp_ready_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
        output dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_resp_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
    );

    modport master (
        output dmi_req_valid_i, dmi_req_addr_i, dmi_req_op_i, dmi_req_data_i, dmi_resp_ready_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
        input  dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_resp_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
    );
endinterface

// File: rtl/dmi_sba_responder.sv
// rtl/dmi_sba_responder.sv - DMI system-bus-access responder (SBCS/SBAddress0/SBData0 to req/gnt/rvalid bus)
// Optional bus watchdog enabled by defining SBA_TIMEOUT_EN.
module dmi_sba_responder #(
    parameter int unsigned BusAw         = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input logic                clk_i,
    input logic                rst_ni,
    dmi_sba_responder_if.slave sba
);
    localparam logic [6:0] AddrSbcs    = 7'h38;
    localparam logic [6:0] AddrSbAddr0 = 7'h39;
    localparam logic [6:0] AddrSbData0 = 7'h3C;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e           state_q;
    logic             resp_valid_q;
    logic [31:0]      resp_data_q;
    logic [31:0]      sbaddr_q;
    logic [31:0]      sbdata_q;
    logic             sbbusyerror_q;
    logic             sbreadonaddr_q;
    logic             sbautoinc_q;
    logic             sbreadondata_q;
    logic [2:0]       sbaccess_q;
    logic [2:0]       sberror_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic [BusAw-1:0] bus_addr_q;
    logic [31:0]      bus_wdata_q;

    logic        sbbusy, dmi_fire, is_rd, is_wr;
    logic        wr_sbcs, wr_addr0, wr_data0, rd_data0;
    logic        busy_viol, can_start, trig_rd, trig_wr, tmo_hit;
    logic [31:0] trig_addr, sbcs_rd, rd_data_d;

`ifdef SBA_TIMEOUT_EN
    logic [31:0] tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
`endif

    always_comb begin
        sbbusy    = (state_q != StIdle);
        dmi_fire  = sba.dmi_req_valid_i && !resp_valid_q;
        is_rd     = dmi_fire && (sba.dmi_req_op_i == 2'd1);
        is_wr     = dmi_fire && (sba.dmi_req_op_i == 2'd2);
        wr_sbcs   = is_wr && (sba.dmi_req_addr_i == AddrSbcs);
        wr_addr0  = is_wr && (sba.dmi_req_addr_i == AddrSbAddr0);
        wr_data0  = is_wr && (sba.dmi_req_addr_i == AddrSbData0);
        rd_data0  = is_rd && (sba.dmi_req_addr_i == AddrSbData0);
        busy_viol = sbbusy && (wr_addr0 || wr_data0 || rd_data0);
        // Sticky errors block new accesses until the debugger clears them
        can_start = !sbbusy && !sbbusyerror_q && (sberror_q == 3'd0);
        trig_rd   = can_start && ((wr_addr0 && sbreadonaddr_q) || (rd_data0 && sbreadondata_q));
        trig_wr   = can_start && wr_data0;
        trig_addr = wr_addr0 ? sba.dmi_req_data_i : sbaddr_q;
`ifdef SBA_TIMEOUT_EN
        tmo_hit   = sbbusy && (tmo_q == TimeoutCycles - 1);
`else
        tmo_hit   = 1'b0;
`endif
        sbcs_rd   = {3'd1, 6'd0, sbbusyerror_q, sbbusy, sbreadonaddr_q, sbaccess_q,
                     sbautoinc_q, sbreadondata_q, sberror_q, 7'd32, 2'd0, 1'b1, 2'd0};
        rd_data_d = '0;
        if (is_rd) begin
            case (sba.dmi_req_addr_i)
                AddrSbcs:    rd_data_d = sbcs_rd;
                AddrSbAddr0: rd_data_d = sbaddr_q;
                AddrSbData0: rd_data_d = sbdata_q;
                default:     rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            sbaddr_q       <= '0;
            sbdata_q       <= '0;
            sbbusyerror_q  <= 1'b0;
            sbreadonaddr_q <= 1'b0;
            sbautoinc_q    <= 1'b0;
            sbreadondata_q <= 1'b0;
            sbaccess_q     <= '0;
            sberror_q      <= '0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
`ifdef SBA_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            if (resp_valid_q && sba.dmi_resp_ready_i) resp_valid_q <= 1'b0;
            if (dmi_fire) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= rd_data_d;
            end
            if (busy_viol) sbbusyerror_q <= 1'b1;
            if (wr_sbcs) begin
                if (sba.dmi_req_data_i[22]) sbbusyerror_q <= 1'b0;
                sbreadonaddr_q <= sba.dmi_req_data_i[20];
                sbaccess_q     <= sba.dmi_req_data_i[19:17];
                sbautoinc_q    <= sba.dmi_req_data_i[16];
                sbreadondata_q <= sba.dmi_req_data_i[15];
                sberror_q      <= sberror_q & ~sba.dmi_req_data_i[14:12];
            end
            if (wr_addr0 && !sbbusy) sbaddr_q <= sba.dmi_req_data_i;
            if (wr_data0 && !sbbusy) sbdata_q <= sba.dmi_req_data_i;
`ifdef SBA_TIMEOUT_EN
            if (sbbusy) tmo_q <= tmo_q + 32'd1;
`endif

            if (tmo_hit) begin
                state_q   <= StIdle;
                bus_req_q <= 1'b0;
                sberror_q <= 3'd1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (trig_rd || trig_wr) begin
                            if (sbaccess_q != 3'd2) begin
                                sberror_q <= 3'd4;
                            end else begin
                                state_q     <= StReq;
                                bus_req_q   <= 1'b1;
                                bus_we_q    <= trig_wr;
                                bus_addr_q  <= {trig_addr[31:2], 2'b00};
                                bus_wdata_q <= sba.dmi_req_data_i;
`ifdef SBA_TIMEOUT_EN
                                tmo_q       <= '0;
`endif
                            end
                        end
                    end
                    StReq: begin
                        if (sba.bus_gnt_i) begin
                            bus_req_q <= 1'b0;
                            state_q   <= StWait;
                        end
                    end
                    StWait: begin
                        if (sba.bus_rvalid_i) begin
                            if (sba.bus_err_i) begin
                                sberror_q <= 3'd2;
                            end else begin
                                if (!bus_we_q) sbdata_q <= sba.bus_rdata_i;
                                if (sbautoinc_q) sbaddr_q <= sbaddr_q + 32'd4;
                            end
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sba.dmi_req_ready_o  = !resp_valid_q;
    assign sba.dmi_resp_valid_o = resp_valid_q;
    assign sba.dmi_resp_data_o  = resp_data_q;
    assign sba.dmi_resp_resp_o  = 2'd0;
    assign sba.bus_req_o        = bus_req_q;
    assign sba.bus_we_o         = bus_we_q;
    assign sba.bus_addr_o       = bus_addr_q;
    assign sba.bus_wdata_o      = bus_wdata_q;
    assign sba.bus_be_o         = 4'hF;
endmodule

// File: tb/tb_dmi_sba_responder.sv
// tb/tb_dmi_sba_responder.sv - table-driven bench with DMI and bus scoreboards for dmi_sba_responder
module tb_dmi_sba_responder;
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    dmi_sba_responder_if #(.BusAw(32)) sif ();
    dmi_sba_responder #(.BusAw(32), .TimeoutCycles(16)) dut (.clk_i(clk), .rst_ni(rst_ni), .sba(sif));

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        bus;
        logic        bwe;
        logic [31:0] baddr;
        logic [31:0] bwdata;
    } vec_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bexp_t;

    vec_t        vt[$];
    bexp_t       bq[$];
    logic [31:0] dq[$];
    int nvec = 0, nerr = 0;
    int gnt_delay = 0, wait_cnt = 0;
    bit never_grant = 0, err_next = 0, pend = 0, p_we = 0;
    logic [31:0] p_addr = '0;

    localparam logic [6:0] SBCS = 7'h38, ADR0 = 7'h39, ADR1 = 7'h3A, DAT0 = 7'h3C;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h2000) ? 32'h1122_3344 : {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d, input logic [31:0] e,
                       input logic bus, input logic bwe, input logic [31:0] ba, input logic [31:0] bw);
        vt.push_back('{op, a, d, e, bus, bwe, ba, bw});
    endtask

    task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        bq.push_back('{we, a, d});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                       input logic [31:0] e, input int hold);
        logic [31:0] x;
        for (int i = 0; i < 20 && !sif.dmi_req_ready_o; i++) cyc();
        chk("req_ready", {31'd0, sif.dmi_req_ready_o}, 32'd1);
        dq.push_back(e);
        sif.dmi_req_valid_i = 1'b1;
        sif.dmi_req_op_i    = op;
        sif.dmi_req_addr_i  = a;
        sif.dmi_req_data_i  = d;
        cyc();
        sif.dmi_req_valid_i = 1'b0;
        sif.dmi_req_op_i    = 2'd0;
        chk("resp_valid", {31'd0, sif.dmi_resp_valid_o}, 32'd1);
        chk("req_ready_busy", {31'd0, sif.dmi_req_ready_o}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk("resp_hold", {31'd0, sif.dmi_resp_valid_o}, 32'd1);
        end
        x = dq.pop_front();
        chk($sformatf("resp_data@%02h", a), sif.dmi_resp_data_o, x);
        chk("resp_resp", {30'd0, sif.dmi_resp_resp_o}, 32'd0);
        sif.dmi_resp_ready_i = 1'b1;
        cyc();
        sif.dmi_resp_ready_i = 1'b0;
        chk("resp_drop", {31'd0, sif.dmi_resp_valid_o}, 32'd0);
    endtask

    task automatic settle();
        repeat (gnt_delay + 6) cyc();
        chk("bus_q_empty", bq.size(), 32'd0);
    endtask

    // Bus target: grants after gnt_delay cycles, returns data one cycle after the grant
    initial begin
        bexp_t b;
        sif.bus_gnt_i = 1'b0; sif.bus_rvalid_i = 1'b0; sif.bus_rdata_i = '0; sif.bus_err_i = 1'b0;
        forever begin
            cyc();
            sif.bus_gnt_i = 1'b0; sif.bus_rvalid_i = 1'b0; sif.bus_err_i = 1'b0;
            if (pend) begin
                sif.bus_rvalid_i = 1'b1;
                sif.bus_rdata_i  = p_we ? 32'h0 : mem_rd(p_addr);
                sif.bus_err_i    = err_next;
                err_next = 1'b0;
                pend     = 1'b0;
            end
            if (sif.bus_req_o && !never_grant) begin
                if (wait_cnt >= gnt_delay) begin
                    sif.bus_gnt_i = 1'b1;
                    wait_cnt = 0;
                    pend     = 1'b1;
                    p_we     = sif.bus_we_o;
                    p_addr   = sif.bus_addr_o;
                    if (bq.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL bus_unexpected: got access we=%0d addr %h expected none", sif.bus_we_o, sif.bus_addr_o);
                    end else begin
                        b = bq.pop_front();
                        chk("bus_we", {31'd0, sif.bus_we_o}, {31'd0, b.we});
                        chk("bus_addr", sif.bus_addr_o, b.addr);
                        chk("bus_be", {28'd0, sif.bus_be_o}, 32'hF);
                        if (b.we) chk("bus_wdata", sif.bus_wdata_o, b.wdata);
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (!sif.bus_req_o) begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_ni = 1'b0;
        sif.dmi_req_valid_i = 1'b0; sif.dmi_req_addr_i = '0; sif.dmi_req_op_i = '0;
        sif.dmi_req_data_i = '0; sif.dmi_resp_ready_i = 1'b0;

        add(2'd2, SBCS, 32'h0004_0000, 32'h0, 0, 0, 0, 0);
        add(2'd1, SBCS, 32'h0, 32'h2004_0404, 0, 0, 0, 0);
        add(2'd2, ADR0, 32'h1000, 32'h0, 0, 0, 0, 0);
        add(2'd2, DAT0, 32'hDEAD_BEEF, 32'h0, 1, 1, 32'h1000, 32'hDEAD_BEEF);
        add(2'd1, SBCS, 32'h0, 32'h2004_0404, 0, 0, 0, 0);
        add(2'd1, ADR0, 32'h0, 32'h1000, 0, 0, 0, 0);
        add(2'd2, SBCS, 32'h0015_0000, 32'h0, 0, 0, 0, 0);
        add(2'd2, ADR0, 32'h2000, 32'h0, 1, 0, 32'h2000, 0);
        add(2'd1, DAT0, 32'h0, 32'h1122_3344, 0, 0, 0, 0);
        add(2'd1, ADR0, 32'h0, 32'h2004, 0, 0, 0, 0);
        add(2'd1, SBCS, 32'h0, 32'h2015_0404, 0, 0, 0, 0);
        add(2'd2, SBCS, 32'h0005_8000, 32'h0, 0, 0, 0, 0);
        add(2'd2, ADR0, 32'h3000, 32'h0, 0, 0, 0, 0);
        add(2'd1, DAT0, 32'h0, 32'h1122_3344, 1, 0, 32'h3000, 0);
        add(2'd1, DAT0, 32'h0, 32'hC0DE_3000, 1, 0, 32'h3004, 0);
        add(2'd1, DAT0, 32'h0, 32'hC0DE_3004, 1, 0, 32'h3008, 0);
        add(2'd1, DAT0, 32'h0, 32'hC0DE_3008, 1, 0, 32'h300C, 0);
        add(2'd1, ADR0, 32'h0, 32'h3010, 0, 0, 0, 0);
        add(2'd2, ADR1, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
        add(2'd1, ADR1, 32'h0, 32'h0, 0, 0, 0, 0);
        add(2'd1, 7'h3B, 32'h0, 32'h0, 0, 0, 0, 0);
        add(2'd0, SBCS, 32'h0, 32'h0, 0, 0, 0, 0);

        repeat (3) cyc();
        chk("rst_resp_valid", {31'd0, sif.dmi_resp_valid_o}, 32'd0);
        chk("rst_resp_data", sif.dmi_resp_data_o, 32'd0);
        chk("rst_bus_req", {31'd0, sif.bus_req_o}, 32'd0);
        chk("rst_bus_we", {31'd0, sif.bus_we_o}, 32'd0);
        chk("rst_bus_addr", sif.bus_addr_o, 32'd0);
        chk("rst_bus_wdata", sif.bus_wdata_o, 32'd0);
        chk("rst_req_ready", {31'd0, sif.dmi_req_ready_o}, 32'd1);
        rst_ni = 1'b1;
        cyc();
        dmi(2'd1, SBCS, 0, 32'h2000_0404, 0);
        dmi(2'd1, DAT0, 0, 32'h0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].bus) push_bus(vt[i].bwe, vt[i].baddr, vt[i].bwdata);
            dmi(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].exp, (i % 5 == 1) ? 2 : 0);
            settle();
        end

        // Busy violation under a slow grant
        dmi(2'd2, SBCS, 32'h0004_0000, 0, 0);
        gnt_delay = 10;
        push_bus(1, 32'h3010, 32'hAAAA_0001);
        dmi(2'd2, DAT0, 32'hAAAA_0001, 0, 0);
        dmi(2'd2, DAT0, 32'hBBBB_0002, 0, 0);
        dmi(2'd1, SBCS, 0, 32'h2064_0404, 0);
        dmi(2'd1, DAT0, 0, 32'hAAAA_0001, 0);
        settle();
        dmi(2'd1, SBCS, 0, 32'h2044_0404, 0);
        dmi(2'd2, SBCS, 32'h0044_0000, 0, 0);
        dmi(2'd1, SBCS, 0, 32'h2004_0404, 0);
        gnt_delay = 0;
        push_bus(1, 32'h3010, 32'hCCCC_0003);
        dmi(2'd2, DAT0, 32'hCCCC_0003, 0, 0);
        settle();

        // Bus error on a read
        dmi(2'd2, SBCS, 32'h0015_0000, 0, 0);
        err_next = 1'b1;
        push_bus(0, 32'h4000, 0);
        dmi(2'd2, ADR0, 32'h4000, 0, 0);
        settle();
        dmi(2'd1, SBCS, 0, 32'h2015_2404, 0);
        dmi(2'd1, DAT0, 0, 32'hCCCC_0003, 0);
        dmi(2'd1, ADR0, 0, 32'h4000, 0);
        dmi(2'd2, ADR0, 32'h5000, 0, 0);
        settle();
        dmi(2'd1, ADR0, 0, 32'h5000, 0);
        dmi(2'd2, SBCS, 32'h0015_7000, 0, 0);
        dmi(2'd1, SBCS, 0, 32'h2015_0404, 0);
        push_bus(0, 32'h6000, 0);
        dmi(2'd2, ADR0, 32'h6000, 0, 0);
        settle();
        dmi(2'd1, DAT0, 0, 32'hC0DE_6000, 0);
        dmi(2'd1, ADR0, 0, 32'h6004, 0);

        // Unsupported access size
        dmi(2'd2, SBCS, 32'h0010_0000, 0, 0);
        dmi(2'd2, ADR0, 32'h7000, 0, 0);
        settle();
        dmi(2'd1, SBCS, 0, 32'h2010_4404, 0);
        dmi(2'd2, SBCS, 32'h0004_7000, 0, 0);
        dmi(2'd1, SBCS, 0, 32'h2004_0404, 0);

`ifdef SBA_TIMEOUT_EN
        never_grant = 1'b1;
        sif.dmi_req_valid_i = 1'b1; sif.dmi_req_op_i = 2'd2;
        sif.dmi_req_addr_i = DAT0; sif.dmi_req_data_i = 32'h55AA_55AA;
        cyc();
        sif.dmi_req_valid_i = 1'b0; sif.dmi_req_op_i = 2'd0;
        sif.dmi_resp_ready_i = 1'b1;
        n = sif.bus_req_o ? 1 : 0;
        for (int i = 0; i < 100 && sif.bus_req_o; i++) begin
            cyc();
            if (sif.bus_req_o) n++;
        end
        sif.dmi_resp_ready_i = 1'b0;
        chk("timeout_req_cycles", n, 32'd16);
        dmi(2'd1, SBCS, 0, 32'h2004_1404, 0);
        never_grant = 1'b0;
        dmi(2'd2, SBCS, 32'h0004_1000, 0, 0);
        dmi(2'd1, SBCS, 0, 32'h2004_0404, 0);
`endif

        // Reset in the middle of an access with a response still pending
        never_grant = 1'b1;
        sif.dmi_req_valid_i = 1'b1; sif.dmi_req_op_i = 2'd2;
        sif.dmi_req_addr_i = DAT0; sif.dmi_req_data_i = 32'h1234_5678;
        cyc();
        sif.dmi_req_valid_i = 1'b0; sif.dmi_req_op_i = 2'd0;
        chk("mid_resp_valid", {31'd0, sif.dmi_resp_valid_o}, 32'd1);
        chk("mid_bus_req", {31'd0, sif.bus_req_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_bus_req", {31'd0, sif.bus_req_o}, 32'd0);
        chk("arst_resp_valid", {31'd0, sif.dmi_resp_valid_o}, 32'd0);
        chk("arst_bus_we", {31'd0, sif.bus_we_o}, 32'd0);
        cyc();
        rst_ni = 1'b1;
        never_grant = 1'b0;
        cyc();
        dmi(2'd1, SBCS, 0, 32'h2000_0404, 0);
        dmi(2'd1, DAT0, 0, 32'h0, 0);
        dmi(2'd1, ADR0, 0, 32'h0, 0);
        repeat (4) cyc();
        chk("final_bus_q_empty", bq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dmi_sba_responder.md
Name: dmi_sba_responder

Overview:
- Responder end of the debug system-bus-access (SBA) path that the debugger drives over DMI.
- Decodes DMI register reads/writes to SBCS, SBAddress0/1 and SBData0, and issues 32-bit memory transactions on a req/gnt/rvalid bus master port.
- Sits between the DMI side of the debug transport and the SoC interconnect; gives the bench a stand-alone SBA target for the JTAG preload and readback flow.

Parameters:
- BusAw, 32, bus address width; only 32 is supported.
- TimeoutCycles, 256, bus watchdog limit in cycles; used only when SBA_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- dmi_req_valid_i  in  1  DMI request valid
- dmi_req_ready_o  out  1  DMI request accepted
- dmi_req_addr_i  in  7  DMI register address
- dmi_req_op_i  in  2  1=read, 2=write, 0/3=nop
- dmi_req_data_i  in  32  DMI write data
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response consumed
- dmi_resp_data_o  out  32  read data; 0 for writes and nops
- dmi_resp_resp_o  out  2  always 0 (OK)
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_we_o  out  1  1=write
- bus_addr_o  out  BusAw  word address, bits [1:0]=0
- bus_wdata_o  out  32  write data
- bus_be_o  out  4  byte enables, always 4'hF
- bus_rvalid_i  in  1  response valid, one cycle
- bus_rdata_i  in  32  read data
- bus_err_i  in  1  error, qualified by bus_rvalid_i

Behaviour:
- Reset: all outputs 0; sbaddress=0; sbdata=0; all writable SBCS fields=0.
- DMI handshake:
  - dmi_req_ready_o = !dmi_resp_valid_o.
  - A request is accepted in cycle N; the response is valid in cycle N+1 and held stable until dmi_resp_ready_i is 1.
  - Read data is the register state at cycle N, before any same-cycle update.
- Register map (any other address reads 0; writes to it are ignored):
  - 0x38 SBCS:
    - [31:29] sbversion=1, RO.
    - [22] sbbusyerror, W1C.
    - [21] sbbusy, RO.
    - [20] sbreadonaddr.
    - [19:17] sbaccess.
    - [16] sbautoincrement.
    - [15] sbreadondata.
    - [14:12] sberror, W1C per bit.
    - [11:5] sbasize=32, RO.
    - [2] sbaccess32=1, RO.
    - All other bits 0.
  - 0x39 SBAddress0: R/W.
  - 0x3A SBAddress1: reads 0, writes ignored.
  - 0x3C SBData0: R/W.
- Access triggers (only when sbbusy=0, sbbusyerror=0 and sberror=0):
  - Write SBAddress0 with sbreadonaddr=1 -> bus read.
  - Write SBData0 -> bus write of the new data.
  - Read SBData0 with sbreadondata=1 -> bus read, started after the old data has been captured for the response.
- If sbaccess!=2 at trigger: no bus access; sberror=4.
- Busy violation: a write to SBAddress0/SBData0, or a read of SBData0, while sbbusy=1:
  - Sets sbbusyerror=1.
  - The register is not modified and no access starts.
  - A read of SBData0 still returns the current sbdata.
- FSM IDLE -> REQ -> WAIT -> IDLE:
  - IDLE: on a trigger, go to REQ and set sbbusy=1.
  - REQ: bus_req_o=1 with addr/we/wdata stable until bus_gnt_i=1, then go to WAIT.
  - WAIT: on bus_rvalid_i:
    - Reads load sbdata from bus_rdata_i.
    - If bus_err_i=1: sberror=2, sbdata unchanged, no increment.
    - Otherwise, if sbautoincrement=1: sbaddress += 4, wrapping modulo 2^32.
    - Clear sbbusy and go to IDLE.
- The earliest trigger-to-trigger spacing is 3 cycles when the grant is immediate.
- Reset mid-transaction: bus_req_o drops immediately, the FSM returns to IDLE, any pending DMI response is discarded, and late bus_rvalid_i is ignored.

Optional Feature:
- Macro SBA_TIMEOUT_EN.
- When defined:
  - A counter runs during REQ and WAIT.
  - When it reaches TimeoutCycles, the access is aborted: bus_req_o=0, sberror=1, sbbusy=0, state=IDLE, no increment.
  - A later bus_rvalid_i for the aborted access is ignored.
- When undefined: no counter; the FSM waits indefinitely and sberror=1 is never produced.

Test Plan:
- Write SBCS=0x0004_0000 (sbaccess=2), SBAddress0=0x1000, SBData0=0xDEADBEEF, bus grant in 0 cycles -> one bus write to 0x1000 with data 0xDEADBEEF, be=F; SBCS read returns sbbusy=0, sberror=0.
- SBCS=0x0015_0000 (sbaccess=2, sbreadonaddr=1, sbautoincrement=1), write SBAddress0=0x2000, memory returns 0x11223344 -> SBData0 reads 0x11223344 and SBAddress0 reads 0x2004.
- SBCS=0x0005_8000 (sbaccess=2, sbautoincrement=1, sbreadondata=1), SBAddress0=0x3000, then 4 SBData0 reads -> bus reads at 0x3000, 0x3004, 0x3008, 0x300C; each DMI read returns the previous word.
- Bus grant delayed 10 cycles and SBData0 written during busy -> sbbusyerror=1, no second access; write SBCS bit 22 = 1 -> sbbusyerror=0 and accesses resume.
- bus_err_i=1 on a read -> sberror=2, sbdata and sbaddress unchanged, next trigger blocked until W1C 0x7000; separately, sbaccess=0 trigger -> sberror=4, no bus_req_o.
- With SBA_TIMEOUT_EN and TimeoutCycles=16, a grant that never arrives -> bus_req_o drops after 16 cycles, sberror=1, sbbusy=0.
